// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel among NR requesters.
// Registered one-hot grant selects the payload. Optional burst lock: RR_ARB_HOLD_EN.
//
// Ports:
//   clk       in  1      rising-edge clock
//   rst_n     in  1      synchronous reset, active low
//   in_valid  in  NR     per-requester valid
//   in_ready  out NR     per-requester ready (granted bit only)
//   in_data   in  NR*DW  requester i payload at [DW*i +: DW]
//   in_last   in  NR     last beat of burst (RR_ARB_HOLD_EN only)
//   out_valid out 1      shared channel valid
//   out_ready in  1      shared channel ready
//   out_data  out DW     payload of granted requester, 0 when idle
//   grant     out NR     registered one-hot grant, 0 = idle
module rr_onehot_arbiter #(
  parameter int NR = 4,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NR-1:0]    in_valid,
  output logic [NR-1:0]    in_ready,
  input  logic [NR*DW-1:0] in_data,
  input  logic [NR-1:0]    in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [NR-1:0]    grant
);

  localparam int PW = (NR > 1) ? $clog2(NR) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    r_state;
  logic [NR-1:0] r_grant;
  logic [PW-1:0] r_ptr;

  logic [PW-1:0] w_pick_idx;
  logic          w_pick_any;
  logic [NR-1:0] w_pick_oh;
  logic          w_gv;
  logic          w_acc;
  logic          w_reload;
  logic          w_drop;
  logic [DW-1:0] w_data;

  // Scan ptr+NR down to ptr+1 so the nearest
  // index after ptr overwrites the others.
  always_comb begin
    int j;
    w_pick_any = 1'b0;
    w_pick_idx = '0;
    j = 0;
    for (int k = NR; k >= 1; k--) begin
      j = (int'(r_ptr) + k) % NR;
      if (in_valid[j]) begin
        w_pick_any = 1'b1;
        w_pick_idx = j[PW-1:0];
      end
    end
  end

  assign w_pick_oh = NR'(1) << w_pick_idx;

  assign w_gv  = |(r_grant & in_valid);
  assign w_acc = w_gv & out_ready;

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NR; i++) begin
      if (r_grant[i]) w_data = w_data | in_data[DW*i +: DW];
    end
  end

`ifdef RR_ARB_HOLD_EN
  logic r_lock;
  logic w_last;

  assign w_last   = |(r_grant & in_last);
  assign w_reload = w_acc & w_last;
  // A locked burst keeps its grant through valid gaps.
  assign w_drop   = ~w_gv & ~r_lock;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock <= 1'b0;
    end else if (r_state == BUSY && w_acc) begin
      r_lock <= ~w_last;
    end
  end
`else
  logic w_unused_last;

  assign w_unused_last = ^in_last;
  assign w_reload      = w_acc;
  assign w_drop        = ~w_gv;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= PW'(NR-1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_grant <= w_pick_oh;
            r_ptr   <= w_pick_idx;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_reload && w_pick_any) begin
            r_grant <= w_pick_oh;
            r_ptr   <= w_pick_idx;
          end else if (w_reload || w_drop) begin
            r_grant <= '0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Gate with rst_n so outputs are quiet while reset is held.
  assign grant     = r_grant;
  assign out_valid = rst_n & w_gv;
  assign in_ready  = rst_n ? (r_grant & {NR{out_ready}}) : '0;
  assign out_data  = rst_n ? w_data : '0;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter (NR=4, DW=8).
// Immediate assertions at each check point.
module tb_rr_onehot_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    in_valid;
  logic [NR-1:0]    in_ready;
  logic [NR*DW-1:0] in_data;
  logic [NR-1:0]    in_last;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [NR-1:0]    grant;

  int total = 0;
  int bad   = 0;

  rr_onehot_arbiter #(.NR(NR), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [NR-1:0] e;
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = {8'h44, 8'h33, 8'h22, 8'hA5};
    in_last   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_oval", 32'(out_valid), 32'h0);
    chk("rst_ird", 32'(in_ready), 32'h0);
    chk("rst_odata", 32'(out_data), 32'h0);
    rst_n = 1'b1;

    // 1: single requester, one-cycle latency
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    #1;
    chk("t1_lat", 32'(out_valid), 32'h0);
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_data", 32'(out_data), 32'hA5);
    chk("t1_ird", 32'(in_ready), 32'h1);
    chk("t1_oval", 32'(out_valid), 32'h1);
    in_valid = '0;
    tick();
    chk("t1_idle", 32'(grant), 32'h0);
    chk("t1_idata", 32'(out_data), 32'h0);

    // 2: all requesting, rotation without bubbles
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = 4'b0001 << (i % 4);
      chk("t2_grant", 32'(grant), 32'(e));
      chk("t2_oval", 32'(out_valid), 32'h1);
    end

    // 3: grant 0010 held under backpressure
    tick();
    chk("t3_pre0", 32'(grant), 32'h1);
    tick();
    chk("t3_pre1", 32'(grant), 32'h2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_grant", 32'(grant), 32'h2);
      chk("t3_oval", 32'(out_valid), 32'h1);
      chk("t3_ird", 32'(in_ready), 32'h0);
      chk("t3_data", 32'(out_data), 32'h22);
    end

    // 4: granted requester 2 drops valid
    out_ready = 1'b1;
    tick();
    chk("t4_g2", 32'(grant), 32'h4);
    out_ready = 1'b0;
    in_valid  = '0;
    tick();
    chk("t4_grant", 32'(grant), 32'h0);
    chk("t4_oval", 32'(out_valid), 32'h0);
    in_valid = 4'b1111;
    tick();
    chk("t4_ptr", 32'(grant), 32'h8);
    chk("t4_data", 32'(out_data), 32'h44);

    // 5: reset while busy
    rst_n = 1'b0;
    #1;
    chk("t5_during", 32'(out_valid), 32'h0);
    tick();
    chk("t5_grant", 32'(grant), 32'h0);
    chk("t5_oval", 32'(out_valid), 32'h0);
    chk("t5_ird", 32'(in_ready), 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("t5_first", 32'(grant), 32'h1);

    // 6: req1 3-beat burst vs req3
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    in_valid = 4'b1010;
    in_last  = '0;
    tick();
    chk("t6_b1", 32'(grant), 32'h2);
    tick();
`ifdef RR_ARB_HOLD_EN
    chk("t6_b2", 32'(grant), 32'h2);
`else
    chk("t6_b2", 32'(grant), 32'h8);
`endif
    tick();
    chk("t6_b3", 32'(grant), 32'h2);
    in_last = 4'b0010;
    tick();
    chk("t6_b4", 32'(grant), 32'h8);
    chk("t6_data", 32'(out_data), 32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
